// File: rtl/axin_pktfifo.sv
// axin_pktfifo: buffers AXIN beats and releases a packet only after its LAST beat.
// Define AXINFIFO_STATS_EN to implement o_drop_count and o_overflow_count.
module axin_pktfifo #(
   parameter int DW     = 64,
   parameter int BW     = 3,
   parameter int LGFIFO = 9
) (
   input  logic          ACLK,
   input  logic          ARESET,
   input  logic          S_AXIN_VALID,
   output logic          S_AXIN_READY,
   input  logic [DW-1:0] S_AXIN_DATA,
   input  logic [BW-1:0] S_AXIN_BYTES,
   input  logic          S_AXIN_LAST,
   input  logic          S_AXIN_ABORT,
   output logic          M_AXIN_VALID,
   input  logic          M_AXIN_READY,
   output logic [DW-1:0] M_AXIN_DATA,
   output logic [BW-1:0] M_AXIN_BYTES,
   output logic          M_AXIN_LAST,
   output logic [15:0]   o_drop_count,
   output logic [15:0]   o_overflow_count
);

   localparam int EW = DW + BW + 1;
   localparam logic [LGFIFO:0] DEPTH = {1'b1, {LGFIFO{1'b0}}};
   localparam logic [LGFIFO:0] ONE   = {{LGFIFO{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      PKT,
      DROP
   } wstate_e;

   wstate_e         state_q, state_d;
   logic [LGFIFO:0] wr_addr_q, wr_addr_d;
   logic [LGFIFO:0] commit_q, commit_d;
   logic [LGFIFO:0] rd_addr_q, rd_addr_d;
   logic [LGFIFO:0] wr_inc, fill;
   logic            full, empty;
   logic            we, drop_inc, ovf_inc;

   logic [EW-1:0]   mem [0:(1<<LGFIFO)-1];
   logic [EW-1:0]   rdata_q;
   logic            rvalid_q, rvalid_d;
   logic            rd_en, load;
   logic            mvalid_q, mvalid_d;
   logic [EW-1:0]   mbeat_q, mbeat_d;

   assign wr_inc       = wr_addr_q + ONE;
   assign fill         = wr_addr_q - rd_addr_q;
   assign full         = (fill == DEPTH);
   assign empty        = (rd_addr_q == commit_q);
   assign S_AXIN_READY = !ARESET;

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      commit_d  = commit_q;
      we        = 1'b0;
      drop_inc  = 1'b0;
      ovf_inc   = 1'b0;
      case (state_q)
         IDLE: begin
            if (S_AXIN_VALID && !S_AXIN_ABORT) begin
               if (full) begin
                  ovf_inc = 1'b1;
                  if (!S_AXIN_LAST) state_d = DROP;
               end else begin
                  we        = 1'b1;
                  wr_addr_d = wr_inc;
                  if (S_AXIN_LAST) commit_d = wr_inc;
                  else             state_d  = PKT;
               end
            end
         end
         PKT: begin
            // Rollback discards every beat of the packet, including this one
            if (S_AXIN_ABORT) begin
               wr_addr_d = commit_q;
               drop_inc  = 1'b1;
               state_d   = IDLE;
            end else if (S_AXIN_VALID) begin
               if (full) begin
                  wr_addr_d = commit_q;
                  ovf_inc   = 1'b1;
                  state_d   = S_AXIN_LAST ? IDLE : DROP;
               end else begin
                  we        = 1'b1;
                  wr_addr_d = wr_inc;
                  if (S_AXIN_LAST) begin
                     commit_d = wr_inc;
                     state_d  = IDLE;
                  end
               end
            end
         end
         DROP: begin
            if (S_AXIN_ABORT || (S_AXIN_VALID && S_AXIN_LAST))
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // rdata_q acts as a one-entry skid so the output can stall without losing a read
   assign load  = rvalid_q && (!mvalid_q || M_AXIN_READY);
   assign rd_en = !empty && (!rvalid_q || load);

   always_comb begin
      rd_addr_d = rd_addr_q;
      rvalid_d  = rvalid_q;
      mvalid_d  = mvalid_q;
      mbeat_d   = mbeat_q;
      if (rd_en) begin
         rd_addr_d = rd_addr_q + ONE;
         rvalid_d  = 1'b1;
      end else if (load) begin
         rvalid_d  = 1'b0;
      end
      if (load) begin
         mvalid_d = 1'b1;
         mbeat_d  = rdata_q;
      end else if (M_AXIN_READY) begin
         mvalid_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK) begin
      if (we)
         mem[wr_addr_q[LGFIFO-1:0]] <= {S_AXIN_LAST, S_AXIN_BYTES, S_AXIN_DATA};
      if (rd_en)
         rdata_q <= mem[rd_addr_q[LGFIFO-1:0]];
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         wr_addr_q <= '0;
         commit_q  <= '0;
         rd_addr_q <= '0;
         rvalid_q  <= 1'b0;
         mvalid_q  <= 1'b0;
         mbeat_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_addr_q <= wr_addr_d;
         commit_q  <= commit_d;
         rd_addr_q <= rd_addr_d;
         rvalid_q  <= rvalid_d;
         mvalid_q  <= mvalid_d;
         mbeat_q   <= mbeat_d;
      end
   end

   assign M_AXIN_VALID = mvalid_q;
   assign M_AXIN_DATA  = mbeat_q[DW-1:0];
   assign M_AXIN_BYTES = mbeat_q[DW+BW-1:DW];
   assign M_AXIN_LAST  = mbeat_q[EW-1];

`ifdef AXINFIFO_STATS_EN
   logic [15:0] drop_q, drop_d;
   logic [15:0] ovf_q, ovf_d;

   always_comb begin
      drop_d = drop_q;
      ovf_d  = ovf_q;
      if (drop_inc && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      if (ovf_inc && ovf_q != 16'hFFFF)   ovf_d  = ovf_q + 16'd1;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         drop_q <= '0;
         ovf_q  <= '0;
      end else begin
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   assign o_drop_count     = drop_q;
   assign o_overflow_count = ovf_q;
`else
   logic unused_stats;
   assign unused_stats     = drop_inc | ovf_inc;
   assign o_drop_count     = '0;
   assign o_overflow_count = '0;
`endif

endmodule

// File: doc/axin_pktfifo.md
Name: axin_pktfifo

Overview:
- Packet-level FIFO placed directly downstream of the 32→64 width converter and CRC checker stage.
- Buffers 64-bit AXIN beats and releases a packet to the consumer only after its LAST beat has been accepted.
- Packets that end in ABORT (for example, CRC failures), or that overflow the buffer, are rolled back and never appear at the output.
- The output stream therefore carries no ABORT signal and may be stalled freely by the downstream router.

Parameters:
- DW, 64, data width in bits.
- BW, 3, byte-count width; value 0 means all DW/8 bytes valid.
- LGFIFO, 9, log2 of FIFO depth in beats (depth is 512 entries of DW+BW+1 bits).

Ports:
- ACLK  input  1  clock.
- ARESET  input  1  asynchronous reset, active-high.
- S_AXIN_VALID  input  1  incoming beat valid.
- S_AXIN_READY  output  1  always 1 out of reset; the network side never stalls.
- S_AXIN_DATA  input  DW  incoming beat data, little-endian.
- S_AXIN_BYTES  input  BW  valid bytes in the beat; 0 means 8.
- S_AXIN_LAST  input  1  final beat of packet.
- S_AXIN_ABORT  input  1  current packet is aborted.
- M_AXIN_VALID  output  1  outgoing beat valid.
- M_AXIN_READY  input  1  consumer accepts beat.
- M_AXIN_DATA  output  DW  outgoing data.
- M_AXIN_BYTES  output  BW  outgoing byte count (same encoding as input).
- M_AXIN_LAST  output  1  final beat of outgoing packet.
- o_drop_count  output  16  packets discarded because of ABORT.
- o_overflow_count  output  16  packets discarded because the FIFO was full.

Behaviour:
- Pointers:
  - wr_addr, wr_commit and rd_addr are each LGFIFO+1 bits wide.
  - Empty when rd_addr == wr_commit.
  - Full when wr_addr - rd_addr == 2^LGFIFO.
- Reset (asynchronous, takes effect immediately):
  - All pointers go to 0 and the write FSM goes to IDLE.
  - M_AXIN_VALID=0; M_AXIN_DATA, M_AXIN_BYTES and M_AXIN_LAST go to 0.
  - Both counters go to 0; S_AXIN_READY=0 while ARESET is high.
  - Buffered contents, committed or not, are lost.
- Write FSM:
  - IDLE:
    - ABORT is ignored.
    - VALID && !full writes a beat at wr_addr and increments wr_addr.
    - Next state is IDLE if LAST is set (wr_commit is set to the new wr_addr), otherwise PKT.
  - PKT:
    - VALID && !ABORT && !full: write the beat. On LAST, commit and go to IDLE.
    - ABORT, with or without VALID: set wr_addr=wr_commit, increment o_drop_count, go to IDLE. The beat carrying ABORT is discarded.
    - VALID && full && !ABORT: set wr_addr=wr_commit, increment o_overflow_count. Go to IDLE if LAST, otherwise DROP.
  - DROP:
    - All beats are discarded.
    - VALID && LAST returns to IDLE.
    - ABORT returns to IDLE with no extra count.
- Beat-level edge cases:
  - VALID && !full in IDLE with ABORT=1: the beat is not written and no counter increments.
  - VALID && full in IDLE: the beat is discarded and o_overflow_count increments. Go to DROP, or stay in IDLE if LAST.
  - A single-beat packet (LAST on the first beat) is committed in one cycle.
  - A packet longer than 2^LGFIFO beats always overflows.
- Read side:
  - The output register is fed by a synchronous RAM read (one cycle).
  - M_AXIN_VALID rises two cycles after the accepted LAST beat when the FIFO was empty and the output register idle.
  - Sustained throughput is one beat per clock while M_AXIN_READY=1 and committed data remains.
  - While M_AXIN_VALID && !M_AXIN_READY, DATA, BYTES and LAST hold stable.
  - rd_addr never passes wr_commit, so uncommitted data is never read.
- Simultaneous events:
  - A write/commit and a read in the same cycle are both honoured.
  - Full is evaluated against rd_addr registered before the current read, so it is conservative by one beat.
- Counters saturate at 16'hFFFF.

Optional Feature:
- Macro: AXINFIFO_STATS_EN.
- With the macro defined: o_drop_count and o_overflow_count are implemented as described.
- Without it: both outputs are tied to 0, the counter registers are removed, and drop/overflow behaviour is otherwise identical.

Test Plan:
- Basic packet, never stalled: 3-beat packet with DATA 64'h0011..77, 64'h8899..FF, 64'h1234 and BYTES 0,0,2; M_AXIN_READY=1 → same 3 beats out with BYTES 0,0,2 and LAST on the third; first M_AXIN_VALID 2 cycles after LAST accepted.
- Abort rollback: 4-beat packet with ABORT on beat 3, followed by a 2-beat good packet → only the 2-beat packet emerges; o_drop_count=1.
- Overflow: LGFIFO=4, M_AXIN_READY=0, 20-beat packet, then a 2-beat packet → no output from the 20-beat packet; o_overflow_count=1; the 2-beat packet emerges once READY=1.
- Backpressure: 8 back-to-back 1-beat packets with M_AXIN_READY toggling every cycle → all 8 out in order; DATA held stable while stalled; 8 LAST pulses.
- Reset mid-packet: ARESET asserted during beat 2 of 5 with two committed packets buffered → M_AXIN_VALID=0 immediately, counters 0; the next full packet passes intact.
- Idle abort and compile option: ABORT pulse in IDLE → no count change and no output. Repeat the abort scenario with AXINFIFO_STATS_EN undefined → o_drop_count stays 0 and the output stream is unchanged.
